// File: rtl/fproc_lut_pkg.sv
// Shared types and helpers for the FPROC measurement/LUT router:
// request modes, per-core FSM states, id decode bases and LUT address compaction.
package fproc_lut_pkg;

  localparam int unsigned MAX_MEAS = 32;

  typedef enum logic [1:0] {
    MODE_WAIT_MEAS = 2'd0,
    MODE_STICKY    = 2'd1,
    MODE_WAIT_LUT  = 2'd2,
    MODE_BAD       = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_MEAS = 3'd1,
    ST_WAIT_LUT  = 3'd2,
    ST_EVAL      = 3'd3,
    ST_RESP      = 3'd4
  } state_e;

  // First id of each mode's range; ranges are N_MEAS, N_MEAS and N_LUT wide.
  function automatic int unsigned id_base(mode_e m, int unsigned n_meas);
    int unsigned b;
    case (m)
      MODE_STICKY:   b = n_meas;
      MODE_WAIT_LUT: b = 32'd2 * n_meas;
      default:       b = 32'd0;
    endcase
    return b;
  endfunction

  // Gather the masked bits LSB-first into a dense address.
  function automatic logic [MAX_MEAS-1:0] compact_addr(logic [MAX_MEAS-1:0] bits,
                                                        logic [MAX_MEAS-1:0] mask);
    logic [MAX_MEAS-1:0] addr;
    logic [5:0]          j;
    addr = '0;
    j    = 6'd0;
    for (int i = 0; i < MAX_MEAS; i++) begin
      if (mask[i]) begin
        addr[j[4:0]] = bits[i];
        j = j + 6'd1;
      end
    end
    return addr;
  endfunction

endpackage

// File: rtl/fproc_lut_router_if.sv
// FPROC request/response bundle between the proc cores (master) and the router (slave).
interface fproc_lut_router_if #(
  parameter int N_CORES = 5,
  parameter int ID_W    = 8,
  parameter int DATA_W  = 32
) ();

  logic [N_CORES-1:0]             fproc_en;
  logic [N_CORES-1:0][ID_W-1:0]   fproc_id;
  logic [N_CORES-1:0]             fproc_ready;
  logic [N_CORES-1:0][DATA_W-1:0] fproc_data;
  logic [N_CORES-1:0]             fproc_err;

  modport master (
    output fproc_en,
    output fproc_id,
    input  fproc_ready,
    input  fproc_data,
    input  fproc_err
  );

  modport slave (
    input  fproc_en,
    input  fproc_id,
    output fproc_ready,
    output fproc_data,
    output fproc_err
  );

endinterface

// File: rtl/fproc_core_fsm.sv
// Per-core request engine: decodes the id, tracks fresh valids and the timeout,
// evaluates the selected LUT and emits a one-cycle registered response.
module fproc_core_fsm
  import fproc_lut_pkg::*;
#(
  parameter int N_MEAS  = 5,
  parameter int N_LUT   = 4,
  parameter int LUT_IN  = 4,
  parameter int ID_W    = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              fproc_en_i,
  input  logic [ID_W-1:0]                   fproc_id_i,
  input  logic [N_MEAS-1:0]                 meas_i,
  input  logic [N_MEAS-1:0]                 meas_valid_i,
  input  logic [N_MEAS-1:0]                 meas_lat_i,
  input  logic [N_LUT-1:0][N_MEAS-1:0]      mask_i,
  input  logic [N_LUT-1:0][(1<<LUT_IN)-1:0] table_i,
  output logic                              fproc_ready_o,
  output logic [DATA_W-1:0]                 fproc_data_o,
  output logic                              fproc_err_o
);

  localparam int CH_W  = (N_MEAS > 1) ? $clog2(N_MEAS) : 1;
  localparam int LUT_W = (N_LUT > 1) ? $clog2(N_LUT) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
  localparam bit   TO_EN       = (TIMEOUT != 0);
  localparam int unsigned STICKY_BASE = id_base(MODE_STICKY, N_MEAS);
  localparam int unsigned LUT_BASE    = id_base(MODE_WAIT_LUT, N_MEAS);
  localparam int unsigned BAD_BASE    = LUT_BASE + N_LUT;

  state_e              state_q;
  logic [N_MEAS-1:0]   seen_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CH_W-1:0]     ch_q;
  logic [LUT_W-1:0]    lut_q;
  logic                ready_q;
  logic [DATA_W-1:0]   data_q;
  logic                err_q;

  logic [31:0]         id_s;
  logic [31:0]         k_s;
  mode_e               mode_s;
  logic [CH_W-1:0]     ch_s;
  logic [LUT_W-1:0]    lut_s;
  logic [N_MEAS-1:0]   seen_nxt_s;
  logic [N_MEAS-1:0]   lut_mask_s;
  logic                lut_hit_s;
  logic                idle_lut_hit_s;
  logic [LUT_IN-1:0]   addr_s;
  logic                timeout_s;

  // Request id decode into mode and channel/LUT index.
  always_comb begin
    id_s   = 32'(fproc_id_i);
    mode_s = MODE_BAD;
    k_s    = 32'd0;
    if (id_s < STICKY_BASE) begin
      mode_s = MODE_WAIT_MEAS;
      k_s    = id_s;
    end else if (id_s < LUT_BASE) begin
      mode_s = MODE_STICKY;
      k_s    = id_s - STICKY_BASE;
    end else if (id_s < BAD_BASE) begin
      mode_s = MODE_WAIT_LUT;
      k_s    = id_s - LUT_BASE;
    end else begin
      mode_s = MODE_BAD;
      k_s    = 32'd0;
    end
    ch_s  = CH_W'(k_s);
    lut_s = LUT_W'(k_s);
  end

  // Completion conditions; masks are read live so a config write lands next cycle.
  always_comb begin
    seen_nxt_s     = seen_q | meas_valid_i;
    lut_mask_s     = mask_i[lut_q];
    lut_hit_s      = ((seen_nxt_s & lut_mask_s) == lut_mask_s);
    idle_lut_hit_s = ((meas_valid_i & mask_i[lut_s]) == mask_i[lut_s]);
    addr_s         = LUT_IN'(compact_addr(MAX_MEAS'(meas_lat_i), MAX_MEAS'(lut_mask_s)));
    timeout_s      = TO_EN && (cnt_q == TO_CNT);
  end

  // Request state machine with registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      seen_q  <= '0;
      cnt_q   <= '0;
      ch_q    <= '0;
      lut_q   <= '0;
      ready_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (fproc_en_i) begin
            seen_q <= meas_valid_i;
            cnt_q  <= CNT_W'(1);
            ch_q   <= ch_s;
            lut_q  <= lut_s;
            case (mode_s)
              MODE_STICKY: begin
                state_q <= ST_RESP;
                ready_q <= 1'b1;
                data_q  <= DATA_W'(meas_lat_i[ch_s]);
              end
              MODE_WAIT_MEAS: begin
                if (meas_valid_i[ch_s]) begin
                  state_q <= ST_RESP;
                  ready_q <= 1'b1;
                  data_q  <= DATA_W'(meas_i[ch_s]);
                end else begin
                  state_q <= ST_WAIT_MEAS;
                end
              end
              MODE_WAIT_LUT: begin
                state_q <= idle_lut_hit_s ? ST_EVAL : ST_WAIT_LUT;
              end
              default: begin
                state_q <= ST_RESP;
                ready_q <= 1'b1;
                err_q   <= 1'b1;
              end
            endcase
          end
        end
        ST_WAIT_MEAS: begin
          seen_q <= seen_nxt_s;
          if (seen_nxt_s[ch_q]) begin
            state_q <= ST_RESP;
            ready_q <= 1'b1;
            data_q  <= DATA_W'(meas_valid_i[ch_q] ? meas_i[ch_q] : meas_lat_i[ch_q]);
          end else if (timeout_s) begin
            state_q <= ST_RESP;
            ready_q <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_LUT: begin
          seen_q <= seen_nxt_s;
          if (lut_hit_s) begin
            state_q <= ST_EVAL;
          end else if (timeout_s) begin
            state_q <= ST_RESP;
            ready_q <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_EVAL: begin
          state_q <= ST_RESP;
          ready_q <= 1'b1;
          data_q  <= DATA_W'(table_i[lut_q][addr_s]);
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign fproc_ready_o = ready_q;
  assign fproc_data_o  = data_q;
  assign fproc_err_o   = err_q;

endmodule

// File: rtl/fproc_lut_router.sv
// Measurement router top: latches measurement bits, holds the LUT mask/table
// config and runs one independent request engine per proc core.
module fproc_lut_router
  import fproc_lut_pkg::*;
#(
  parameter int N_CORES = 5,
  parameter int N_MEAS  = N_CORES,
  parameter int N_LUT   = 4,
  parameter int LUT_IN  = 4,
  parameter int ID_W    = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  fproc_lut_router_if.slave          fproc,
  input  logic [N_MEAS-1:0]          meas,
  input  logic [N_MEAS-1:0]          meas_valid,
  input  logic                       cfg_we,
  input  logic [$clog2(N_LUT):0]     cfg_addr,
  input  logic [31:0]                cfg_data
);

  localparam int TBL_W  = 1 << LUT_IN;
  localparam int LUT_W  = $clog2(N_LUT);
  localparam int CFG_AW = LUT_W + 1;

  logic [N_MEAS-1:0]             meas_lat_q;
  logic [N_LUT-1:0][N_MEAS-1:0]  mask_q;
  logic [N_LUT-1:0][TBL_W-1:0]   table_q;

  logic [LUT_W-1:0]              cfg_lut_s;
  logic [N_CORES-1:0]            ready_s;
  logic [N_CORES-1:0][DATA_W-1:0] data_s;
  logic [N_CORES-1:0]            err_s;

  assign cfg_lut_s = cfg_addr[CFG_AW-1:1];

  // Last-seen value of every measurement channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      meas_lat_q <= '0;
    end else begin
      meas_lat_q <= (meas_lat_q & ~meas_valid) | (meas & meas_valid);
    end
  end

  // LUT configuration store; address LSB picks table over mask.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q  <= '0;
      table_q <= '0;
    end else if (cfg_we && (int'(cfg_lut_s) < N_LUT)) begin
      if (cfg_addr[0]) begin
        table_q[cfg_lut_s] <= TBL_W'(cfg_data);
      end else begin
        mask_q[cfg_lut_s] <= N_MEAS'(cfg_data);
      end
    end
  end

  for (genvar c = 0; c < N_CORES; c++) begin : g_core
    fproc_core_fsm #(
      .N_MEAS  (N_MEAS),
      .N_LUT   (N_LUT),
      .LUT_IN  (LUT_IN),
      .ID_W    (ID_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
    ) u_fsm (
      .clk           (clk),
      .reset         (reset),
      .fproc_en_i    (fproc.fproc_en[c]),
      .fproc_id_i    (fproc.fproc_id[c]),
      .meas_i        (meas),
      .meas_valid_i  (meas_valid),
      .meas_lat_i    (meas_lat_q),
      .mask_i        (mask_q),
      .table_i       (table_q),
      .fproc_ready_o (ready_s[c]),
      .fproc_data_o  (data_s[c]),
      .fproc_err_o   (err_s[c])
    );
  end

  assign fproc.fproc_ready = ready_s;
  assign fproc.fproc_data  = data_s;
  assign fproc.fproc_err   = err_s;

endmodule

// File: tb/tb_fproc_lut_router.sv
// Self-checking bench for fproc_lut_router: table-driven single-cycle requests plus
// hand-written multi-cycle sequences, all checked through a response scoreboard.
module tb_fproc_lut_router;

  localparam int NC = 5;
  localparam int NM = 5;
  localparam int NL = 4;

  typedef struct {
    int          core;
    int          cyc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    int          core;
    logic [7:0]  id;
    logic [4:0]  valid;
    logic [4:0]  meas;
    logic [31:0] data;
    logic        err;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [4:0]  meas;
  logic [4:0]  meas_valid;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_data;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_on = 1'b0;
  exp_t sb[$];
  vec_t vec[11];
  int   t;

  fproc_lut_router_if #(.N_CORES(NC), .ID_W(8), .DATA_W(32)) bus ();

  fproc_lut_router #(
    .N_CORES (NC),
    .N_MEAS  (NM),
    .N_LUT   (NL),
    .LUT_IN  (4),
    .ID_W    (8),
    .DATA_W  (32),
    .TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fproc      (bus),
    .meas       (meas),
    .meas_valid (meas_valid),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: match every ready against the oldest expectation for that core.
  always @(negedge clk) begin
    if (mon_on) begin
      for (int c = 0; c < NC; c++) begin
        if (bus.fproc_ready[c]) begin
          int idx;
          idx = -1;
          for (int q = 0; q < sb.size(); q++) begin
            if (idx < 0 && sb[q].core == c) idx = q;
          end
          n_vec++;
          if (idx < 0) begin
            n_err++;
            $display("FAIL unexpected_ready core%0d cyc=%0d data=%h err=%b", c, cyc,
                     bus.fproc_data[c], bus.fproc_err[c]);
          end else begin
            if (sb[idx].cyc != cyc || bus.fproc_data[c] !== sb[idx].data ||
                bus.fproc_err[c] !== sb[idx].err) begin
              n_err++;
              $display("FAIL resp core%0d: got cyc=%0d data=%h err=%b, expected cyc=%0d data=%h err=%b",
                       c, cyc, bus.fproc_data[c], bus.fproc_err[c],
                       sb[idx].cyc, sb[idx].data, sb[idx].err);
            end
            sb.delete(idx);
          end
        end
      end
      for (int q = sb.size() - 1; q >= 0; q--) begin
        if (sb[q].cyc < cyc) begin
          n_vec++;
          n_err++;
          $display("FAIL missing_ready core%0d: no ready by cyc=%0d, expected at cyc=%0d",
                   sb[q].core, cyc, sb[q].cyc);
          sb.delete(q);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    bus.fproc_en = '0;
    meas_valid   = '0;
    cfg_we       = 1'b0;
  endtask

  task automatic req(int c, logic [7:0] id);
    bus.fproc_en[c] = 1'b1;
    bus.fproc_id[c] = id;
  endtask

  task automatic drive_meas(logic [4:0] v, logic [4:0] m);
    meas_valid = v;
    meas       = m;
  endtask

  task automatic expect_rsp(int c, int at, logic [31:0] d, logic e);
    sb.push_back('{c, at, d, e});
  endtask

  task automatic cfg_write(logic [2:0] a, logic [31:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    step();
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    // Single-cycle requests; latch state evolves from vector to vector.
    vec[0]  = '{3, 8'd7,   5'b00000, 5'b00000, 32'd1, 1'b0};
    vec[1]  = '{2, 8'd2,   5'b00100, 5'b00000, 32'd0, 1'b0};
    vec[2]  = '{3, 8'd7,   5'b00000, 5'b00000, 32'd0, 1'b0};
    vec[3]  = '{2, 8'd3,   5'b01000, 5'b01000, 32'd1, 1'b0};
    vec[4]  = '{1, 8'd8,   5'b00000, 5'b00000, 32'd1, 1'b0};
    vec[5]  = '{1, 8'd14,  5'b00000, 5'b00000, 32'd0, 1'b1};
    vec[6]  = '{0, 8'd255, 5'b00000, 5'b00000, 32'd0, 1'b1};
    vec[7]  = '{4, 8'd5,   5'b00000, 5'b00000, 32'd0, 1'b0};
    vec[8]  = '{0, 8'd4,   5'b10000, 5'b10000, 32'd1, 1'b0};
    vec[9]  = '{2, 8'd9,   5'b00000, 5'b00000, 32'd1, 1'b0};
    vec[10] = '{4, 8'd0,   5'b00001, 5'b00000, 32'd0, 1'b0};

    reset        = 1'b1;
    bus.fproc_en = '0;
    bus.fproc_id = '0;
    meas         = '0;
    meas_valid   = '0;
    cfg_we       = 1'b0;
    cfg_addr     = '0;
    cfg_data     = '0;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_on = 1'b1;
    @(negedge clk);
    chk("reset_ready", 32'(bus.fproc_ready), 32'd0);
    chk("reset_data0", bus.fproc_data[0], 32'd0);
    chk("reset_err", 32'(bus.fproc_err), 32'd0);
    step();

    // Wait on channel 2, valid three cycles later.
    t = cyc;
    req(0, 8'd2);
    step(); step(); step();
    drive_meas(5'b00100, 5'b00100);
    expect_rsp(0, t + 4, 32'd1, 1'b0);
    step(); step();

    for (int i = 0; i < 11; i++) begin
      t = cyc;
      req(vec[i].core, vec[i].id);
      drive_meas(vec[i].valid, vec[i].meas);
      expect_rsp(vec[i].core, t + 1, vec[i].data, vec[i].err);
      step(); step();
    end

    // A valid before the request must not satisfy it.
    drive_meas(5'b00010, 5'b00010);
    step();
    t = cyc;
    req(2, 8'd1);
    step(); step(); step();
    drive_meas(5'b00010, 5'b00010);
    expect_rsp(2, t + 4, 32'd1, 1'b0);
    step(); step();

    // LUT0: mask 0b101, table 0b0100.
    cfg_write(3'b000, 32'h0000_0005);
    cfg_write(3'b001, 32'h0000_0004);
    t = cyc;
    req(0, 8'd10);
    step();
    drive_meas(5'b00001, 5'b00000);
    step();
    drive_meas(5'b00100, 5'b00100);
    expect_rsp(0, t + 4, 32'd1, 1'b0);
    step(); step(); step();
    t = cyc;
    req(0, 8'd10);
    step();
    drive_meas(5'b00101, 5'b00101);
    expect_rsp(0, t + 3, 32'd0, 1'b0);
    step(); step(); step();

    // LUT2 over non-contiguous channels 1,3,4 -> addr 6.
    cfg_write(3'b100, 32'h0000_001A);
    cfg_write(3'b101, 32'h0000_0040);
    t = cyc;
    req(4, 8'd12);
    step();
    drive_meas(5'b11010, 5'b11000);
    expect_rsp(4, t + 3, 32'd1, 1'b0);
    step(); step(); step();

    // Three cores on channel 4, one valid serves all (fresh 0 over latched 1).
    t = cyc;
    req(0, 8'd4); req(1, 8'd4); req(2, 8'd4);
    step(); step();
    drive_meas(5'b10000, 5'b00000);
    expect_rsp(0, t + 3, 32'd0, 1'b0);
    expect_rsp(1, t + 3, 32'd0, 1'b0);
    expect_rsp(2, t + 3, 32'd0, 1'b0);
    step(); step(); step();

    // Timeout with a re-request ignored mid-wait and during RESP.
    t = cyc;
    req(3, 8'd1);
    expect_rsp(3, t + 17, 32'd0, 1'b1);
    step();
    while (cyc < t + 5) step();
    req(3, 8'd5);
    step();
    while (cyc < t + 17) step();
    req(3, 8'd5);
    step();
    req(3, 8'd8);
    expect_rsp(3, t + 19, 32'd1, 1'b0);
    step(); step(); step();

    // Reset while two cores wait: no ready, config and latches cleared.
    req(0, 8'd0);
    req(1, 8'd10);
    step(); step();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    t = cyc;
    req(3, 8'd8);
    expect_rsp(3, t + 1, 32'd0, 1'b0);
    step(); step();
    drive_meas(5'b00101, 5'b00101);
    step(); step();
    cfg_write(3'b000, 32'h0000_0005);
    t = cyc;
    req(1, 8'd10);
    step();
    drive_meas(5'b00101, 5'b00100);
    expect_rsp(1, t + 3, 32'd0, 1'b0);
    step(); step(); step();
    t = cyc;
    req(0, 8'd2);
    step();
    drive_meas(5'b00100, 5'b00100);
    expect_rsp(0, t + 2, 32'd1, 1'b0);
    step(); step(); step();

    repeat (3) step();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fproc_lut_router.md
# fproc_lut_router

Next-generation feedback-processor measurement router. Serves FPROC requests from `N_CORES` proc cores against `N_MEAS` measurement channels. Supports three request modes:
- wait for a fresh measurement;
- immediate read of the last latched value;
- evaluate one of `N_LUT` run-time-programmable LUTs over a masked measurement subset.

Sits between the readout/discrimination outputs and the proc cores' FPROC ports, and adds a per-request timeout.

## Interface
- `N_CORES`, 5, number of proc cores served.
- `N_MEAS`, `N_CORES`, number of measurement channels (≤32).
- `N_LUT`, 4, number of programmable LUTs.
- `LUT_IN`, 4, max LUT address bits (≤5).
- `ID_W`, 8, width of FPROC request id.
- `DATA_W`, 32, width of FPROC return data.
- `TIMEOUT`, 4096, max wait cycles per request (0 = never time out).

Ports:
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `fproc_en` in `N_CORES`: per-core request strobe.
- `fproc_id` in `N_CORES`×`ID_W`: per-core request id.
- `fproc_ready` out `N_CORES`: one-cycle result strobe.
- `fproc_data` out `N_CORES`×`DATA_W`: result, valid with ready.
- `fproc_err` out `N_CORES`: with ready; high on bad id or timeout.
- `meas` in `N_MEAS`: measurement bits.
- `meas_valid` in `N_MEAS`: per-channel valid strobe.
- `cfg_we` in 1: config write strobe.
- `cfg_addr` in `$clog2(N_LUT)+1`: {lut index, sel}; sel=0 mask, sel=1 table.
- `cfg_data` in 32: mask (low `N_MEAS` bits) or table (low 2^`LUT_IN` bits).

## Operation
Id decode (k = id − base):
- [0,`N_MEAS`): WAIT_MEAS on channel id.
- [`N_MEAS`,2`N_MEAS`): STICKY read of channel k.
- [2`N_MEAS`,2`N_MEAS`+`N_LUT`): WAIT_LUT k.
- Any other id: BAD.

Measurement latch:
- On `meas_valid[i]`, `meas_lat[i]`←`meas[i]`.
- Reset value is 0.

Per-core FSM, states IDLE, WAIT_MEAS, WAIT_LUT, EVAL, RESP:
- IDLE + `fproc_en`:
  - STICKY → RESP with `meas_lat[k]`.
  - BAD → RESP with data 0, err=1.
  - Otherwise → wait state. Clear the core's `seen[N_MEAS]` vector and timeout counter.
- While waiting, `seen[i]` is set by `meas_valid[i]`. A valid in the same cycle as `fproc_en` counts.
- WAIT_MEAS: when `seen[id]` is set (or the valid arrives this cycle) → RESP with that measurement bit.
- WAIT_LUT: when all bits of `mask[k]` are seen → EVAL.
- EVAL: address = the masked `meas_lat` bits compacted LSB-first, truncated to `LUT_IN` bits. Data = `table[k][addr]`. → RESP.
- Empty mask: WAIT_LUT goes to EVAL immediately with addr 0.
- Timeout: counter reaches `TIMEOUT` in a wait state → RESP with data 0, err=1.
- RESP: drive ready for one cycle → IDLE.
- `fproc_en` while not IDLE is ignored (no queueing).
- Data is the result bit zero-extended to `DATA_W`.
- Cores are fully independent; any number may wait on the same channel, and one `meas_valid` satisfies all of them.

Config:
- `cfg_we` writes mask/table on the next edge.
- A write to a LUT a core is currently waiting on or evaluating takes effect on the next cycle's compare/eval.

## Timing
Reset values: `fproc_ready`=0, `fproc_data`=0, `fproc_err`=0, all FSMs IDLE, latches, masks and tables all 0. Reset mid-request aborts it with no ready.

Latency, ready asserted at:
- STICKY/BAD: request at t → t+1.
- WAIT_MEAS: the later of request t and valid v → max(t,v)+1.
- WAIT_LUT: last needed valid at v → v+2 (EVAL stage).
- Timeout: t+`TIMEOUT`+1.

Back-to-back: a new request is accepted at the ready cycle+1 earliest.

## Structure
Package `fproc_lut_pkg`:
- mode enum (WAIT_MEAS, STICKY, WAIT_LUT, BAD);
- FSM state enum;
- id base constants;
- `compact_addr` function.

Sub-module `fproc_core_fsm`: one per core via generate. It holds `seen`, the timeout counter and the RESP register. The top holds the latches and the config RAM.

## Test plan
- Reset, then core0 id=2: `meas_valid[2]` with `meas[2]`=1 at t+3 → `fproc_ready[0]` at t+4, data=1, err=0.
- Core1 sticky id=`N_MEAS`+3 after `meas[3]`=1 was latched → ready next cycle with data 1. A request with id=2`N_MEAS`+`N_LUT` → ready next cycle, err=1.
- LUT0 mask=0b101, table=0b0100:
  - `meas[0]`=0 then `meas[2]`=1 on later valids → addr 2, data 1, ready two cycles after the `meas[2]` valid;
  - second run with both 1 → addr 3, data 0.
- Cores 0, 1 and 2 all wait on channel 4; a single valid → all three ready on the same cycle.
- `TIMEOUT`=16, no valids → ready at t+17 with err=1. `fproc_en` re-asserted while waiting is ignored.
- Assert reset while two cores are waiting → no ready. After reset, LUT tables read 0 and a fresh request behaves normally.
